// File: rtl/naval_shot_controller_if.sv
// Button, ship-map and status signals between the Batalha Naval shot controller
// and its surroundings (debounce logic, 1-to-64 shot demux, ship-map lookup, display).
interface naval_shot_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       ship_hit;
    logic [5:0] sel;
    logic       fire_pulse;
    logic [6:0] shots_left;
    logic [6:0] hits;
    logic       result_valid;
    logic       result_hit;
    logic       repeat_shot;
    logic       busy;
    logic       game_won;
    logic       game_lost;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_fire, ship_hit,
        output sel, fire_pulse, shots_left, hits, result_valid, result_hit,
               repeat_shot, busy, game_won, game_lost
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_fire, ship_hit,
        input  sel, fire_pulse, shots_left, hits, result_valid, result_hit,
               repeat_shot, busy, game_won, game_lost
    );
endinterface

// File: rtl/naval_shot_controller.sv
// Cursor, fire sequencing and score keeping for the 64-cell shot demux.
// Every output is a Moore decode of registered state, so buttons never reach outputs combinationally.
module naval_shot_controller #(
    parameter int MAX_SHOTS  = 20,
    parameter int SHIP_CELLS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    naval_shot_controller_if.slave        bus
);
    localparam logic [6:0] LP_SHOTS = 7'(MAX_SHOTS);
    localparam logic [6:0] LP_SHIPS = 7'(SHIP_CELLS);

    typedef enum logic [2:0] {
        IDLE, CHECK, REJECT, FIRE, RESULT, OVER
    } state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_row, r_col;
    logic [63:0] r_mask;
    logic [6:0]  r_shots, r_hits;
    logic        r_hit_flag, r_won, r_lost;
    logic [5:0]  w_sel;
    logic        w_idle_move;

    assign w_sel       = {r_row, r_col};
    assign w_idle_move = (r_state == IDLE) && !bus.btn_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.btn_fire) w_next = CHECK;
            CHECK:   w_next = r_mask[w_sel] ? REJECT : FIRE;
            REJECT:  w_next = IDLE;
            FIRE:    w_next = RESULT;
            RESULT:  w_next = ((r_hits == LP_SHIPS) || (r_shots == 7'd0)) ? OVER : IDLE;
            OVER:    w_next = OVER;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_mask     <= 64'd0;
            r_shots    <= LP_SHOTS;
            r_hits     <= 7'd0;
            r_hit_flag <= 1'b0;
            r_won      <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            // Opposing pulses cancel; 3-bit arithmetic gives the modulo-8 wrap.
            if (w_idle_move) begin
                if (bus.btn_up && !bus.btn_down)      r_row <= r_row - 3'd1;
                else if (bus.btn_down && !bus.btn_up) r_row <= r_row + 3'd1;
                if (bus.btn_left && !bus.btn_right)      r_col <= r_col - 3'd1;
                else if (bus.btn_right && !bus.btn_left) r_col <= r_col + 3'd1;
            end
            if (r_state == FIRE) begin
                r_mask[w_sel] <= 1'b1;
                r_shots       <= r_shots - 7'd1;
                r_hit_flag    <= bus.ship_hit;
                if (bus.ship_hit) r_hits <= r_hits + 7'd1;
            end
            // A win on the last shot outranks running out of shots.
            if (r_state == RESULT) begin
                if (r_hits == LP_SHIPS)    r_won  <= 1'b1;
                else if (r_shots == 7'd0)  r_lost <= 1'b1;
            end
        end
    end

    assign bus.sel          = w_sel;
    assign bus.fire_pulse   = (r_state == FIRE);
    assign bus.shots_left   = r_shots;
    assign bus.hits         = r_hits;
    assign bus.result_valid = (r_state == RESULT);
    assign bus.result_hit   = (r_state == RESULT) && r_hit_flag;
    assign bus.repeat_shot  = (r_state == REJECT);
    assign bus.busy         = (r_state != IDLE);
    assign bus.game_won     = (r_state == OVER) && r_won;
    assign bus.game_lost    = (r_state == OVER) && r_lost;
endmodule

// File: tb/tb_naval_shot_controller.sv
// Directed bench: a default-parameter controller plus a 3-shot and a 2-shot game
// instance, all sharing the same button stimulus.
module tb_naval_shot_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b_up = 0, b_down = 0, b_left = 0, b_right = 0, b_fire = 0, b_hit = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    naval_shot_controller_if if_m ();
    naval_shot_controller_if if_l ();
    naval_shot_controller_if if_w ();

    assign if_m.btn_up = b_up;  assign if_m.btn_down = b_down;  assign if_m.btn_left = b_left;
    assign if_m.btn_right = b_right;  assign if_m.btn_fire = b_fire;  assign if_m.ship_hit = b_hit;
    assign if_l.btn_up = b_up;  assign if_l.btn_down = b_down;  assign if_l.btn_left = b_left;
    assign if_l.btn_right = b_right;  assign if_l.btn_fire = b_fire;  assign if_l.ship_hit = b_hit;
    assign if_w.btn_up = b_up;  assign if_w.btn_down = b_down;  assign if_w.btn_left = b_left;
    assign if_w.btn_right = b_right;  assign if_w.btn_fire = b_fire;  assign if_w.ship_hit = b_hit;

    naval_shot_controller #(.MAX_SHOTS(20), .SHIP_CELLS(10)) u_main (.clk(clk), .rst(rst), .bus(if_m));
    naval_shot_controller #(.MAX_SHOTS(3),  .SHIP_CELLS(2))  u_lose (.clk(clk), .rst(rst), .bus(if_l));
    naval_shot_controller #(.MAX_SHOTS(2),  .SHIP_CELLS(2))  u_win  (.clk(clk), .rst(rst), .bus(if_w));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic press(input int which);
        case (which)
            0: b_up = 1;  1: b_down = 1;  2: b_left = 1;  3: b_right = 1;  default: b_fire = 1;
        endcase
        tick();
        b_up = 0; b_down = 0; b_left = 0; b_right = 0; b_fire = 0;
    endtask

    // Full accepted shot: fire sampled, then CHECK, FIRE, RESULT, back to IDLE/OVER.
    task automatic do_shot();
        press(4); tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick();
        tests++; if (if_m.sel !== 6'd0) begin fails++; $display("FAIL reset_sel got %b exp 000000", if_m.sel); end
        tests++; if (if_m.shots_left !== 7'd20) begin fails++; $display("FAIL reset_shots got %0d exp 20", if_m.shots_left); end
        tests++; if (if_m.hits !== 7'd0) begin fails++; $display("FAIL reset_hits got %0d exp 0", if_m.hits); end
        tests++; if ({if_m.busy, if_m.fire_pulse, if_m.result_valid, if_m.repeat_shot, if_m.game_won, if_m.game_lost} !== 6'd0)
            begin fails++; $display("FAIL reset_flags got %b exp 000000",
                {if_m.busy, if_m.fire_pulse, if_m.result_valid, if_m.repeat_shot, if_m.game_won, if_m.game_lost}); end
        rst = 1'b0; tick();
    endtask

    task automatic test_cursor();
        press(1); press(1); press(3); press(3); press(3);
        tests++; if (if_m.sel !== 6'b010_011) begin fails++; $display("FAIL cursor_move got %b exp 010011", if_m.sel); end
        do_reset();
        press(0);
        tests++; if (if_m.sel !== 6'b111_000) begin fails++; $display("FAIL cursor_row_wrap got %b exp 111000", if_m.sel); end
        press(2);
        tests++; if (if_m.sel !== 6'b111_111) begin fails++; $display("FAIL cursor_col_wrap got %b exp 111111", if_m.sel); end
        b_up = 1; b_down = 1; b_right = 1; tick(); b_up = 0; b_down = 0; b_right = 0;
        tests++; if (if_m.sel !== 6'b111_000) begin fails++; $display("FAIL cursor_cancel got %b exp 111000", if_m.sel); end
        b_left = 1; b_right = 1; b_down = 1; tick(); b_left = 0; b_right = 0; b_down = 0;
        tests++; if (if_m.sel !== 6'b000_000) begin fails++; $display("FAIL cursor_lr_cancel got %b exp 000000", if_m.sel); end
    endtask

    task automatic test_fire_hit();
        do_reset();
        for (int i = 0; i < 3; i++) press(1);
        for (int i = 0; i < 5; i++) press(3);
        b_hit = 1;
        press(4);
        tests++; if (if_m.fire_pulse !== 1'b0 || if_m.busy !== 1'b1) begin fails++; $display("FAIL hit_check_cycle got fp=%b busy=%b exp fp=0 busy=1", if_m.fire_pulse, if_m.busy); end
        tick();
        tests++; if (if_m.fire_pulse !== 1'b1 || if_m.sel !== 6'b011_101) begin fails++; $display("FAIL hit_fire got fp=%b sel=%b exp fp=1 sel=011101", if_m.fire_pulse, if_m.sel); end
        tick();
        tests++; if ({if_m.fire_pulse, if_m.result_valid, if_m.result_hit} !== 3'b011) begin fails++; $display("FAIL hit_result got fp/rv/rh=%b exp 011", {if_m.fire_pulse, if_m.result_valid, if_m.result_hit}); end
        tests++; if (if_m.hits !== 7'd1 || if_m.shots_left !== 7'd19) begin fails++; $display("FAIL hit_counts got hits=%0d shots=%0d exp 1 19", if_m.hits, if_m.shots_left); end
        tick();
        tests++; if ({if_m.result_valid, if_m.result_hit, if_m.busy} !== 3'b000) begin fails++; $display("FAIL hit_idle got rv/rh/busy=%b exp 000", {if_m.result_valid, if_m.result_hit, if_m.busy}); end
    endtask

    task automatic test_repeat();
        press(4); tick();
        tests++; if (if_m.repeat_shot !== 1'b1 || if_m.fire_pulse !== 1'b0) begin fails++; $display("FAIL repeat_strobe got rep=%b fp=%b exp 1 0", if_m.repeat_shot, if_m.fire_pulse); end
        tick();
        tests++; if ({if_m.repeat_shot, if_m.fire_pulse, if_m.busy} !== 3'b000) begin fails++; $display("FAIL repeat_idle got rep/fp/busy=%b exp 000", {if_m.repeat_shot, if_m.fire_pulse, if_m.busy}); end
        tests++; if (if_m.hits !== 7'd1 || if_m.shots_left !== 7'd19) begin fails++; $display("FAIL repeat_counts got hits=%0d shots=%0d exp 1 19", if_m.hits, if_m.shots_left); end
        b_hit = 0;
    endtask

    task automatic test_reset_in_fire();
        do_reset();
        b_fire = 1; b_right = 1; tick(); b_fire = 0; b_right = 0;
        tests++; if (if_m.sel !== 6'b000_000) begin fails++; $display("FAIL fire_priority got %b exp 000000", if_m.sel); end
        tick();
        tests++; if (if_m.fire_pulse !== 1'b1) begin fails++; $display("FAIL rst_fire_pre got fp=%b exp 1", if_m.fire_pulse); end
        #2 rst = 1'b1; #1;
        tests++; if (if_m.fire_pulse !== 1'b0 || if_m.shots_left !== 7'd20) begin fails++; $display("FAIL rst_async got fp=%b shots=%0d exp 0 20", if_m.fire_pulse, if_m.shots_left); end
        tick(); rst = 1'b0; tick();
        press(4); tick();
        tests++; if (if_m.fire_pulse !== 1'b1 || if_m.repeat_shot !== 1'b0) begin fails++; $display("FAIL rst_mask_clear got fp=%b rep=%b exp 1 0", if_m.fire_pulse, if_m.repeat_shot); end
        tick(); tick();
        tests++; if (if_m.shots_left !== 7'd19 || if_m.hits !== 7'd0) begin fails++; $display("FAIL rst_refire_counts got shots=%0d hits=%0d exp 19 0", if_m.shots_left, if_m.hits); end
    endtask

    task automatic test_lose();
        int pulses;
        do_reset();
        b_hit = 0;
        do_shot(); press(3);
        do_shot(); press(3);
        tests++; if (if_l.busy !== 1'b0 || if_l.shots_left !== 7'd1) begin fails++; $display("FAIL lose_midgame got busy=%b shots=%0d exp 0 1", if_l.busy, if_l.shots_left); end
        do_shot();
        tests++; if ({if_l.game_lost, if_l.game_won, if_l.busy} !== 3'b101) begin fails++; $display("FAIL lose_over got lost/won/busy=%b exp 101", {if_l.game_lost, if_l.game_won, if_l.busy}); end
        tests++; if (if_l.shots_left !== 7'd0 || if_l.hits !== 7'd0) begin fails++; $display("FAIL lose_counts got shots=%0d hits=%0d exp 0 0", if_l.shots_left, if_l.hits); end
        pulses = 0;
        press(3); press(1);
        b_fire = 1;
        for (int i = 0; i < 5; i++) begin tick(); if (if_l.fire_pulse) pulses++; end
        b_fire = 0;
        tests++; if (pulses !== 0 || if_l.sel !== 6'b000_010) begin fails++; $display("FAIL lose_frozen got pulses=%0d sel=%b exp 0 000010", pulses, if_l.sel); end
        tests++; if (if_l.game_lost !== 1'b1) begin fails++; $display("FAIL lose_held got %b exp 1", if_l.game_lost); end
    endtask

    task automatic test_win();
        do_reset();
        b_hit = 1;
        do_shot(); press(3); do_shot();
        b_hit = 0;
        tests++; if ({if_w.game_won, if_w.game_lost} !== 2'b10) begin fails++; $display("FAIL win_priority got won/lost=%b exp 10", {if_w.game_won, if_w.game_lost}); end
        tests++; if (if_w.hits !== 7'd2 || if_w.shots_left !== 7'd0) begin fails++; $display("FAIL win_counts got hits=%0d shots=%0d exp 2 0", if_w.hits, if_w.shots_left); end
        tests++; if (if_m.busy !== 1'b0 || if_m.hits !== 7'd2) begin fails++; $display("FAIL win_main_continues got busy=%b hits=%0d exp 0 2", if_m.busy, if_m.hits); end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_fire_hit();
        test_repeat();
        test_reset_in_fire();
        test_lose();
        test_win();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
